cc_setpoint_arbiter: RTL and testbench
======================================

# cc_setpoint_arbiter

Fixed-priority arbiter and sequencer for the shared 4:1 x/y/z setpoint multiplexer that feeds the robot's kinematics stage. Four command sources each present an x/y/z setpoint triple on their mux input and strobe an update. This block:
- grants one source at a time and drives the mux select;
- inserts a one-cycle settle after each switch;
- pulses a load strobe telling downstream registers when the mux output is valid;
- drops a silent source through a watchdog so the robot falls back to the safe default (mux input 1, idle).

## Interface
Parameters:
- TIMEOUT_CYCLES, 50000, watchdog limit in clock cycles (1 ms at 50 MHz); must be ≥ 2
- CNT_WIDTH, 16, watchdog counter width; 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
- CC_SETPOINT_ARBITER_CLOCK_50  input  1  system clock; all logic on its rising edge
- CC_SETPOINT_ARBITER_RESET_InHigh  input  1  synchronous, active-high reset
- CC_SETPOINT_ARBITER_update_InBus  input  4  per-source one-cycle strobe; bit i maps to mux input i+1. A source holds its data stable from its strobe until its next strobe.
- CC_SETPOINT_ARBITER_enable_InBus  input  4  per-source enable; a disabled source is never granted
- CC_SETPOINT_ARBITER_select_OutBus  output  2  mux select, i.e. index of the granted source
- CC_SETPOINT_ARBITER_grant_OutBus  output  4  one-hot grant, or 0 when idle
- CC_SETPOINT_ARBITER_active_Out  output  1  grant_OutBus != 0
- CC_SETPOINT_ARBITER_load_Out  output  1  one-cycle strobe: mux output valid, downstream captures
- CC_SETPOINT_ARBITER_timeout_Out  output  1  one-cycle pulse: granted source dropped by the watchdog

## Operation
Sources and priority:
- Candidate set: req = update_InBus & enable_InBus.
- Priority is fixed; source 0 is highest.

States: IDLE, SETTLE, ACTIVE. All outputs are registered.

- **IDLE**
  - Outputs: select=00, grant=0000, load=0.
  - If req≠0: grant the highest-priority set bit k, set select=k, go to SETTLE.
- **SETTLE** (mux switching; lasts 1 cycle)
  - Next edge: load=1, go to ACTIVE, clear the watchdog.
  - Exception: a req bit j of higher priority than k restarts SETTLE with j; load stays 0.
  - Lower-priority and same-source strobes are ignored; the exit load captures the held data.
- **ACTIVE**, granted k. Conditions are evaluated per cycle, highest row first:
  1. enable[k]=0: release. If req≠0, go to SETTLE on the highest-priority req; otherwise go to IDLE. No timeout pulse.
  2. req bit j<k: preempt. Set select=j, go to SETTLE, no load. The pending update[k] is discarded.
  3. update[k]=1: load=1 next cycle, watchdog cleared.
  4. Watchdog == TIMEOUT_CYCLES: next edge goes to IDLE with timeout=1 and grant cleared.
  5. Otherwise: watchdog increments.
  - Strobes from lower-priority sources (j>k) are ignored.

Watchdog:
- Value is 0 on the cycle load is high.
- Increments by 1 each following ACTIVE cycle without a load.
- Never wraps, because expiry exits ACTIVE.
- An own update in the same cycle as expiry wins: load is asserted, no timeout.

Reset:
- Next edge after RESET_InHigh=1: IDLE, select=00, grant=0000, active=0, load=0, timeout=0, watchdog=0.
- Reset mid-SETTLE or mid-ACTIVE: no load or timeout pulse is emitted.
- Inputs are ignored while reset is held.

## Timing
- Strobe at cycle t from IDLE → select and grant valid at t+1 (SETTLE) → load=1 at t+2.
- ACTIVE own strobe at t → load=1 at t+1.
- Preemption strobe at t → new select at t+1 → load at t+2.
- Timeout:
  - last load at cycle L, no further strobes → timeout=1 and grant=0000 at L+TIMEOUT_CYCLES+1;
  - active=0 from that same cycle.
- load and timeout are never both high in the same cycle.
- load is never high in IDLE or on a cycle where select changed.
- Back-to-back own strobes every cycle give load every cycle.

## Test plan
- Reset, then strobe update=0100, enable=1111 at t → t+1: select=10, grant=0100; t+2: load=1, active=1; every other cycle load=0.
- Granted source 2, then update=0001 at t → t+1: select=00, grant=0001, load=0; t+2: load=1. Then update=1000 → no change, no load.
- TIMEOUT_CYCLES=8, source 1 loads at L, no further strobes → timeout=1 and grant=0000 at L+9, select=00. Repeat with an own strobe at L+8 → load at L+9, no timeout.
- Granted source 0, drop enable[0] while update=0010 in the same cycle → next cycle SETTLE on source 1 (select=01), load one cycle later, no timeout pulse.
- Simultaneous strobes update=1110 from IDLE → source 1 granted. enable=0000 with update=1111 → stays IDLE, all outputs 0.
- Assert reset during SETTLE and again during ACTIVE → next cycle all outputs 0. No load or timeout pulse is emitted afterward until a new strobe arrives.

Source files
------------

// File: rtl/cc_setpoint_arbiter.sv
// Fixed-priority arbiter/sequencer for the shared 4:1 x/y/z setpoint mux.
// Grants one source, inserts a settle cycle, strobes load, and drops silent sources.
module cc_setpoint_arbiter #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int CNT_WIDTH      = 16
) (
   input  logic       CC_SETPOINT_ARBITER_CLOCK_50,
   input  logic       CC_SETPOINT_ARBITER_RESET_InHigh,
   input  logic [3:0] CC_SETPOINT_ARBITER_update_InBus,
   input  logic [3:0] CC_SETPOINT_ARBITER_enable_InBus,
   output logic [1:0] CC_SETPOINT_ARBITER_select_OutBus,
   output logic [3:0] CC_SETPOINT_ARBITER_grant_OutBus,
   output logic       CC_SETPOINT_ARBITER_active_Out,
   output logic       CC_SETPOINT_ARBITER_load_Out,
   output logic       CC_SETPOINT_ARBITER_timeout_Out
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t               r_state;
   logic [1:0]           r_sel;
   logic [3:0]           r_grant;
   logic                 r_active;
   logic                 r_load;
   logic                 r_timeout;
   logic [CNT_WIDTH-1:0] r_wdog;

   logic [3:0] w_req;
   logic [1:0] w_req_idx;
   logic [3:0] w_higher;

   // Lowest set bit wins; callers only use the result when the vector is nonzero.
   function automatic logic [1:0] f_prio(input logic [3:0] v);
      logic [1:0] idx;
      if (v[0]) begin
         idx = 2'd0;
      end else if (v[1]) begin
         idx = 2'd1;
      end else if (v[2]) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

   function automatic logic [3:0] f_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   assign w_req     = CC_SETPOINT_ARBITER_update_InBus & CC_SETPOINT_ARBITER_enable_InBus;
   assign w_req_idx = f_prio(w_req);
   // Requests strictly above the currently selected source.
   assign w_higher  = w_req & (f_onehot(r_sel) - 4'd1);

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge CC_SETPOINT_ARBITER_CLOCK_50) begin
      if (CC_SETPOINT_ARBITER_RESET_InHigh) begin
         r_state   <= ST_IDLE;
         r_sel     <= 2'd0;
         r_grant   <= 4'd0;
         r_active  <= 1'b0;
         r_load    <= 1'b0;
         r_timeout <= 1'b0;
         r_wdog    <= '0;
      end else begin
         r_load    <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req != 4'd0) begin
                  r_sel    <= w_req_idx;
                  r_grant  <= f_onehot(w_req_idx);
                  r_active <= 1'b1;
                  r_state  <= ST_SETTLE;
               end else begin
                  r_sel    <= 2'd0;
                  r_grant  <= 4'd0;
                  r_active <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (w_higher != 4'd0) begin
                  r_sel   <= w_req_idx;
                  r_grant <= f_onehot(w_req_idx);
               end else begin
                  r_load  <= 1'b1;
                  r_wdog  <= '0;
                  r_state <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (!CC_SETPOINT_ARBITER_enable_InBus[r_sel]) begin
                  r_wdog <= '0;
                  if (w_req != 4'd0) begin
                     r_sel   <= w_req_idx;
                     r_grant <= f_onehot(w_req_idx);
                     r_state <= ST_SETTLE;
                  end else begin
                     r_sel    <= 2'd0;
                     r_grant  <= 4'd0;
                     r_active <= 1'b0;
                     r_state  <= ST_IDLE;
                  end
               end else if (w_higher != 4'd0) begin
                  r_sel   <= w_req_idx;
                  r_grant <= f_onehot(w_req_idx);
                  r_state <= ST_SETTLE;
               end else if (CC_SETPOINT_ARBITER_update_InBus[r_sel]) begin
                  r_load <= 1'b1;
                  r_wdog <= '0;
               end else if (r_wdog == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                  r_timeout <= 1'b1;
                  r_sel     <= 2'd0;
                  r_grant   <= 4'd0;
                  r_active  <= 1'b0;
                  r_wdog    <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_wdog <= r_wdog + CNT_WIDTH'(1);
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_sel    <= 2'd0;
               r_grant  <= 4'd0;
               r_active <= 1'b0;
               r_wdog   <= '0;
            end
         endcase
      end
   end

   assign CC_SETPOINT_ARBITER_select_OutBus = r_sel;
   assign CC_SETPOINT_ARBITER_grant_OutBus  = r_grant;
   assign CC_SETPOINT_ARBITER_active_Out    = r_active;
   assign CC_SETPOINT_ARBITER_load_Out      = r_load;
   assign CC_SETPOINT_ARBITER_timeout_Out   = r_timeout;

endmodule

// File: tb/tb_cc_setpoint_arbiter.sv
// Directed self-checking bench for cc_setpoint_arbiter with a short watchdog.
module tb_cc_setpoint_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] upd;
   logic [3:0] ena;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       act;
   logic       ld;
   logic       tmo;

   int n_cmp = 0;
   int n_err = 0;

   cc_setpoint_arbiter #(
      .TIMEOUT_CYCLES(8),
      .CNT_WIDTH     (4)
   ) dut (
      .CC_SETPOINT_ARBITER_CLOCK_50     (clk),
      .CC_SETPOINT_ARBITER_RESET_InHigh (rst),
      .CC_SETPOINT_ARBITER_update_InBus (upd),
      .CC_SETPOINT_ARBITER_enable_InBus (ena),
      .CC_SETPOINT_ARBITER_select_OutBus(sel),
      .CC_SETPOINT_ARBITER_grant_OutBus (gnt),
      .CC_SETPOINT_ARBITER_active_Out   (act),
      .CC_SETPOINT_ARBITER_load_Out     (ld),
      .CC_SETPOINT_ARBITER_timeout_Out  (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] e_sel, input logic [3:0] e_gnt,
                          input logic e_act, input logic e_ld, input logic e_tmo);
      chk({tag, ".sel"},     32'(sel), 32'(e_sel));
      chk({tag, ".grant"},   32'(gnt), 32'(e_gnt));
      chk({tag, ".active"},  32'(act), 32'(e_act));
      chk({tag, ".load"},    32'(ld),  32'(e_ld));
      chk({tag, ".timeout"}, 32'(tmo), 32'(e_tmo));
   endtask

   // Consume current inputs on the next rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      upd = 4'b1111;
      ena = 4'b1111;
      tick();
      chk_all("reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("reset_held", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      upd = 4'b0000;
      tick();
      chk_all("idle", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Basic grant of source 2
      upd = 4'b0100;
      tick();
      chk_all("s2_settle", 2'd2, 4'b0100, 1'b1, 1'b0, 1'b0);
      upd = 4'b0000;
      tick();
      chk_all("s2_load", 2'd2, 4'b0100, 1'b1, 1'b1, 1'b0);
      tick();
      chk_all("s2_quiet", 2'd2, 4'b0100, 1'b1, 1'b0, 1'b0);

      // Preemption by source 0, lower-priority strobe ignored
      upd = 4'b0001;
      tick();
      chk_all("pre_settle", 2'd0, 4'b0001, 1'b1, 1'b0, 1'b0);
      upd = 4'b0000;
      tick();
      chk_all("pre_load", 2'd0, 4'b0001, 1'b1, 1'b1, 1'b0);
      upd = 4'b1000;
      tick();
      chk_all("low_ignored", 2'd0, 4'b0001, 1'b1, 1'b0, 1'b0);

      // Enable drop with simultaneous lower request
      upd = 4'b0010;
      ena = 4'b1110;
      tick();
      chk_all("drop_settle", 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0);
      upd = 4'b0000;
      ena = 4'b1111;
      tick();
      chk_all("drop_load", 2'd1, 4'b0010, 1'b1, 1'b1, 1'b0);

      // Watchdog expiry: load at L, timeout at L+9
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk_all($sformatf("wd_wait%0d", i), 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0);
      end
      tick();
      chk_all("wd_expire", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
      tick();
      chk_all("wd_after", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Own strobe at L+8 wins over expiry
      upd = 4'b0010;
      tick();
      upd = 4'b0000;
      tick();
      chk_all("wd2_load", 2'd1, 4'b0010, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         tick();
      end
      chk_all("wd2_L8", 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0);
      upd = 4'b0010;
      tick();
      chk_all("wd2_rescue", 2'd1, 4'b0010, 1'b1, 1'b1, 1'b0);

      // Back-to-back own strobes
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all($sformatf("b2b%0d", i), 2'd1, 4'b0010, 1'b1, 1'b1, 1'b0);
      end
      upd = 4'b0000;
      tick();
      chk_all("b2b_end", 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0);

      // Simultaneous strobes from IDLE
      rst = 1'b1;
      tick();
      chk_all("rst2", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      upd = 4'b1110;
      tick();
      chk_all("simul_settle", 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0);
      upd = 4'b0000;
      tick();
      chk_all("simul_load", 2'd1, 4'b0010, 1'b1, 1'b1, 1'b0);

      // All disabled stays idle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ena = 4'b0000;
      upd = 4'b1111;
      tick();
      chk_all("dis_idle1", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("dis_idle2", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Reset during SETTLE
      ena = 4'b1111;
      upd = 4'b0100;
      tick();
      chk_all("rs_settle", 2'd2, 4'b0100, 1'b1, 1'b0, 1'b0);
      upd = 4'b0000;
      rst = 1'b1;
      tick();
      chk_all("rs_reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_all($sformatf("rs_post%0d", i), 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      end

      // Reset during ACTIVE, then no watchdog pulse afterwards
      upd = 4'b0100;
      tick();
      upd = 4'b0000;
      tick();
      chk_all("ra_load", 2'd2, 4'b0100, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk_all("ra_reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk_all($sformatf("ra_post%0d", i), 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
